// File: rtl/sersub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package sersub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-index counter width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b, LSB first, one bit per clock through a single full_sub_cell.
// Define SERSUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor
    import sersub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERSUB_OVF_EN
    output logic             borrow,
    output logic             ovf
`else
    output logic             borrow
`endif
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] diff_reg;
    logic [CW-1:0]    cnt;
    logic             bin_reg;
    logic             done_reg;
    logic             last_bit;
    logic             cell_a;
    logic             cell_b;
    logic             cell_d;
    logic             cell_bout;

    assign last_bit = (cnt == LAST_CNT);
    assign cell_a   = a_reg[cnt];
    assign cell_b   = b_reg[cnt];

    full_sub_cell u_cell (
        .a    (cell_a),
        .b    (cell_b),
        .bin  (bin_reg),
        .d    (cell_d),
        .bout (cell_bout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (last_bit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // done is registered off the DONE state so it lands one cycle after RUN ends,
    // giving a fixed WIDTH+1 edge latency from the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            diff_reg <= '0;
            cnt      <= '0;
            bin_reg  <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg   <= a;
                        b_reg   <= b;
                        bin_reg <= 1'b0;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    diff_reg <= {cell_d, diff_reg[WIDTH-1:1]};
                    bin_reg  <= cell_bout;
                    cnt      <= last_bit ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef SERSUB_OVF_EN
    logic ovf_reg;

    // The bit shifted in on the last RUN cycle becomes diff's MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (state == RUN && last_bit) begin
            ovf_reg <= (a_reg[WIDTH-1] != b_reg[WIDTH-1]) && (cell_d != a_reg[WIDTH-1]);
        end
    end

    assign ovf = ovf_reg;
`endif

    assign busy   = (state != IDLE);
    assign done   = done_reg;
    assign diff   = diff_reg;
    assign borrow = bin_reg;

endmodule
